multicycle_shift_unit: RTL and testbench
========================================

// Module: multicycle_shift_unit
// PURPOSE
//  Parametrised, iterative shift unit for the execute stage; generalises the fixed
//  right-shift stages to any WIDTH and to four shift modes.
//  Each BUSY cycle applies STAGES_PER_CYCLE conditional power-of-two shift stages.
//  Valid/ready handshakes on input and output let the pipeline stall around a
//  multi-cycle shift.
// PARAMETERS
//  WIDTH             32  operand/result width; power of two, >= 4
//  STAGES_PER_CYCLE  1   shift stages applied per BUSY cycle; 1..log2(WIDTH)
//  (derived) SHAMT_W = log2(WIDTH); NUM_PASSES = ceil(SHAMT_W / STAGES_PER_CYCLE)
// PORTS
//  clock       in   1        rising-edge clock
//  reset_n     in   1        asynchronous, active-low reset
//  in_valid    in   1        request present
//  in_ready    out  1        unit can accept a request
//  in_data     in   WIDTH    operand
//  in_shamt    in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_mode     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//  out_valid   out  1        result present
//  out_ready   in   1        consumer accepts result
//  out_data    out  WIDTH    shifted result
// BEHAVIOUR
//  - One clock and one reset. reset_n is asynchronous and active-low.
//  - Reset (asynchronous, any state, including mid-operation): state=IDLE,
//    in_ready=1, out_valid=0, out_data=0, internal data/shamt/mode/pass counter=0.
//    Any in-flight request is discarded; no partial result is ever presented.
//  - FSM states IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on an edge with in_valid=1, latch data/shamt/mode, pass=0, go to BUSY.
//    in_data/in_shamt/in_mode are sampled only at the accept edge.
//  - BUSY: each edge applies stages k = pass*STAGES_PER_CYCLE .. +STAGES_PER_CYCLE-1
//    (only k < SHAMT_W). Stage k shifts by 2^k if shamt[k]=1, else passes through.
//    pass increments; after pass NUM_PASSES-1, go to DONE.
//  - Latency: out_valid rises exactly NUM_PASSES edges after the accept edge.
//    Latency is fixed, including shamt=0. Default configuration: 5 cycles.
//  - DONE: out_data holds the result. On an edge with out_ready=1, go to IDLE.
//    out_ready=0 holds the state and out_data indefinitely.
//    No same-cycle DONE->accept: a new request is accepted at the earliest one
//    cycle after the result is consumed.
//  - out_data is registered and changes only on the DONE-entry edge or on reset.
//    It keeps its last value in IDLE and BUSY.
//  - Fill rules per stage:
//    - SLL: zero-fill from the LSB.
//    - SRL: zero-fill from the MSB.
//    - SRA: fill with the operand MSB latched at accept (sign preserved across passes).
//    - ROR: bits shifted out at the LSB re-enter at the MSB.
//  - Stage composition is exact, so any shamt in 0..WIDTH-1 gives the single-shift
//    result. No overflow or flag outputs.
//  - in_valid while BUSY or DONE is ignored (in_ready=0); the source holds the request.
// STRUCTURE
//  - Shared package/header holds the mode encodings (MODE_SLL=2'b00, MODE_SRL=2'b01,
//    MODE_SRA=2'b10, MODE_ROR=2'b11), the FSM state encodings and a clog2 helper.
//  - Sub-module shift_stage #(WIDTH, DIST): combinational. Inputs: data, enable,
//    mode, fill_bit. Output: data shifted by DIST when enable=1, else unchanged.
//  - Top generates SHAMT_W shift_stage instances and muxes one pass group per cycle
//    by the pass counter.
//  - Top also contains the FSM, the pass counter and the result register.
// TESTING (WIDTH=32, STAGES_PER_CYCLE=1 unless stated)
//  1. SRA 0x80000000 by 4 -> out_valid exactly 5 cycles after accept; out_data=0xF8000000.
//     Same operand, SRL by 4 -> 0x08000000.
//  2. SLL 0x00000001 by 31 -> 0x80000000; ROR 0x0000000F by 4 -> 0xF0000000;
//     shamt=0 (any mode) -> data unchanged, latency still 5.
//  3. Backpressure: out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0,
//     new in_valid ignored. out_ready=1 -> IDLE next edge; next request accepted.
//  4. Reset mid-operation: assert reset_n=0 two cycles after accept, asynchronously
//     between edges -> outputs go to reset values immediately; after release no
//     out_valid until a fresh request.
//  5. STAGES_PER_CYCLE=5: latency 1 cycle. STAGES_PER_CYCLE=2: latency 3 cycles.
//     Both configs, 2000 random mode/shamt/data requests -> match a reference
//     model every time.
//  6. Back-to-back stream with out_ready tied high -> in_ready pulses once per
//     NUM_PASSES+2 cycles; all results in order and correct.

Source files
------------

// File: rtl/multicycle_shift_unit_pkg.sv
// Shared encodings for the iterative shift unit: shift modes, FSM states and a
// constant-foldable clog2 used to size shift amounts and pass counters.
package multicycle_shift_unit_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/multicycle_shift_unit_stage.sv
// One conditional power-of-two shift stage. Purely combinational; passes the
// operand through untouched when enable is low.
module shift_stage
    import multicycle_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = data_in;
        case (mode)
            MODE_SLL: shifted = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
            MODE_SRL: shifted = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
            MODE_SRA: shifted = {{DIST{fill_bit}}, data_in[WIDTH-1:DIST]};
            default:  shifted = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        endcase
        data_out = enable ? shifted : data_in;
    end

endmodule

// File: rtl/multicycle_shift_unit.sv
// Iterative barrel shifter: each BUSY cycle applies one group of power-of-two
// stages selected by the pass counter; result is registered on DONE entry.
module multicycle_shift_unit
    import multicycle_shift_unit_pkg::*;
#(
    parameter  int WIDTH            = 32,
    parameter  int STAGES_PER_CYCLE = 1,
    localparam int SHAMT_W          = clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int NUM_PASSES = (SHAMT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
    localparam int PASS_W     = (NUM_PASSES > 1) ? clog2(NUM_PASSES) : 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         mode_q, mode_d;
    logic               sign_q, sign_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    logic [WIDTH-1:0]   grp_out [NUM_PASSES];
    logic [WIDTH-1:0]   pass_res;

    // Every stage exists physically; the pass counter picks which group's output is
    // written back, so each group always sees the current working operand.
    for (genvar p = 0; p < NUM_PASSES; p++) begin : g_pass
        for (genvar s = 0; s < STAGES_PER_CYCLE; s++) begin : g_st
            localparam int K = p * STAGES_PER_CYCLE + s;
            logic [WIDTH-1:0] din, dout;
            if (s == 0) begin : g_head
                assign din = data_q;
            end else begin : g_link
                assign din = g_st[s-1].dout;
            end
            if (K < SHAMT_W) begin : g_stage
                shift_stage #(.WIDTH(WIDTH), .DIST(1 << K)) u_stage (
                    .data_in  (din),
                    .enable   (shamt_q[K]),
                    .mode     (mode_q),
                    .fill_bit (sign_q),
                    .data_out (dout)
                );
            end else begin : g_thru
                assign dout = din;
            end
        end
        assign grp_out[p] = g_st[STAGES_PER_CYCLE-1].dout;
    end

    always_comb begin
        pass_res = grp_out[0];
        for (int p = 0; p < NUM_PASSES; p++) begin
            if (pass_q == PASS_W'(p)) pass_res = grp_out[p];
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        mode_d     = mode_q;
        sign_d     = sign_q;
        pass_d     = pass_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    mode_d  = in_mode;
                    sign_d  = in_data[WIDTH-1];
                    pass_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d = pass_res;
                if (pass_q == LAST_PASS) begin
                    out_data_d = pass_res;
                    pass_d     = '0;
                    state_d    = ST_DONE;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            shamt_q    <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            pass_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            mode_q     <= mode_d;
            sign_q     <= sign_d;
            pass_q     <= pass_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Directed and random checks of multicycle_shift_unit in three stage groupings
// (1, 5 and 2 stages per cycle) driven in lockstep from shared request inputs.
module tb_multicycle_shift_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b0;

    logic [2:0]  rdy, vld;
    logic [31:0] dat [3];

    int n_vec = 0;
    int n_err = 0;
    int LAT [3] = '{5, 1, 3};

    always #5 clock = ~clock;

    multicycle_shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]));

    multicycle_shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]));

    multicycle_shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [4:0] s,
                                              input logic [31:0] d);
        logic [63:0] dd;
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin dd = {d, d} >> s; return dd[31:0]; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request to all three units, measure each latency, check, consume.
    task automatic run_req(input string tag, input logic [1:0] m, input logic [4:0] s,
                           input logic [31:0] d, input logic [31:0] exp);
        int lat [3];
        lat = '{-1, -1, -1};
        in_valid = 1'b1; in_mode = m; in_shamt = s; in_data = d;
        tick();
        in_valid = 1'b0; in_data = ~d; in_shamt = ~s; in_mode = ~m;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            for (int c = 0; c < 3; c++) if (vld[c] && lat[c] < 0) lat[c] = cyc;
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s/c%0d latency", tag, c), 32'(lat[c]), 32'(LAT[c]));
            chk($sformatf("%s/c%0d data", tag, c), dat[c], exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " in_ready after consume"}, 32'(rdy), 32'h7);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  s;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t dvec [9] = '{
        '{2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000},
        '{2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000},
        '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000},
        '{2'b11, 5'd4,  32'h0000_000F, 32'hF000_0000},
        '{2'b10, 5'd0,  32'h1234_5678, 32'h1234_5678},
        '{2'b11, 5'd0,  32'h8000_0001, 32'h8000_0001},
        '{2'b10, 5'd31, 32'h7FFF_FFF0, 32'h0000_0000},
        '{2'b11, 5'd16, 32'h1234_5678, 32'h5678_1234},
        '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF}
    };

    vec_t svec [4] = '{
        '{2'b00, 5'd1,  32'h0000_0003, 32'h0000_0006},
        '{2'b01, 5'd8,  32'hABCD_0000, 32'h00AB_CD00},
        '{2'b10, 5'd16, 32'hC000_0000, 32'hFFFF_C000},
        '{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000}
    };

    initial begin
        int seen;
        int idx_in, idx_out, last_rdy;
        logic [1:0]  rm;
        logic [4:0]  rs;
        logic [31:0] rd;

        // Reset values while held in reset, then again just after release.
        #12;
        chk("reset in_ready", 32'(rdy), 32'h7);
        chk("reset out_valid", 32'(vld), 32'h0);
        chk("reset out_data", dat[0], 32'h0);
        reset_n = 1'b1;
        tick();
        chk("post-reset idle", {29'd0, rdy}, 32'h7);

        for (int i = 0; i < 9; i++)
            run_req($sformatf("dir%0d", i), dvec[i].m, dvec[i].s, dvec[i].d, dvec[i].e);

        // Backpressure: hold DONE for 10 cycles with a competing request present.
        in_valid = 1'b1; in_mode = 2'b00; in_shamt = 5'd8; in_data = 32'h0000_00AB;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("bp reach done", 32'(vld[0]), 32'h1);
        in_valid = 1'b1; in_mode = 2'b01; in_shamt = 5'd4; in_data = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp hold data %0d", i), dat[0], 32'h0000_AB00);
            chk($sformatf("bp hold ready %0d", i), 32'(rdy[0]), 32'h0);
            chk($sformatf("bp hold valid %0d", i), 32'(vld[0]), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp idle valid", 32'(vld[0]), 32'h0);
        chk("bp idle ready", 32'(rdy[0]), 32'h1);
        chk("bp idle data kept", dat[0], 32'h0000_AB00);
        tick();
        in_valid = 1'b0;
        chk("bp next accepted", 32'(rdy[0]), 32'h0);
        repeat (4) tick();
        chk("bp busy data kept", dat[0], 32'h0000_AB00);
        chk("bp busy no valid", 32'(vld[0]), 32'h0);
        tick();
        chk("bp next valid", 32'(vld[0]), 32'h1);
        chk("bp next data", dat[0], 32'h0111_1111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random requests against the reference model for all three groupings.
        for (int i = 0; i < 2000; i++) begin
            rm = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            rd = $urandom();
            run_req($sformatf("rnd%0d", i), rm, rs, rd, ref_shift(rm, rs, rd));
        end

        // Asynchronous reset two cycles into an operation.
        in_valid = 1'b1; in_mode = 2'b11; in_shamt = 5'd3; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("mid-reset in_ready", 32'(rdy), 32'h7);
        chk("mid-reset out_valid", 32'(vld), 32'h0);
        chk("mid-reset out_data c0", dat[0], 32'h0);
        chk("mid-reset out_data c1", dat[1], 32'h0);
        #2 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vld != 3'b000) seen++;
        end
        chk("no valid after reset", 32'(seen), 32'h0);

        // Streaming with out_ready tied high: one accept per NUM_PASSES+2 cycles.
        out_ready = 1'b1;
        idx_in = 0; idx_out = 0; last_rdy = -1;
        for (int cyc = 0; cyc < 80 && idx_out < 4; cyc++) begin
            in_valid = 1'b0;
            if (rdy[0] && idx_in < 4) begin
                if (last_rdy >= 0) chk("stream ready period", 32'(cyc - last_rdy), 32'd7);
                last_rdy = cyc;
                in_valid = 1'b1; in_mode = svec[idx_in].m;
                in_shamt = svec[idx_in].s; in_data = svec[idx_in].d;
                idx_in++;
            end
            if (vld[0]) begin
                chk($sformatf("stream data %0d", idx_out), dat[0], svec[idx_out].e);
                idx_out++;
            end
            if (idx_out < 4) tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream results", 32'(idx_out), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
